// File: rtl/uart_tx_fifo.sv
// Queued 8N1 UART transmitter: FIFO of DEPTH bytes feeding a baud-divided serialiser.
// Optional even parity bit (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ = 21477272,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     tx_clear,
  input  logic [7:0]               tx_DI,
  input  logic                     tx_we,
  output logic                     tx_full,
  output logic                     tx_empty,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     tx_busy,
  output logic                     tx_overflow,
  output logic                     uart_port_DO
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BW  = $clog2(DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, ovf_q, ovf_d;
  logic          push_c, pop_c;

  state_e        state_q;
  logic [BW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          line_q, busy_q;
  logic          line_c, bit_end_c;

  // FIFO control: a pop frees a slot in the same cycle, so a write while full is kept then
  always_comb begin
    pop_c    = (state_q == S_IDLE) && !empty_q;
    push_c   = tx_we && (!full_q || pop_c);
    wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    ovf_d    = ovf_q | (tx_we & full_q & ~pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= tx_DI;
  end

  always_ff @(posedge clk) begin
    if (tx_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  assign bit_end_c = (cnt_q == BW'(DIV - 1));

  // Line level implied by the current state; registered into line_q one cycle later
  always_comb begin
    line_c = 1'b1;
    case (state_q)
      S_START:    line_c = 1'b0;
      S_DATA:     line_c = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   line_c = ^shift_q;
`endif
      default:    line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      line_q <= line_c;
      busy_q <= (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!empty_q) begin
            shift_q <= mem[rd_ptr_q];
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end_c) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_c) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end_c) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_full      = full_q;
  assign tx_empty     = empty_q;
  assign tx_count     = count_q;
  assign tx_busy      = busy_q;
  assign tx_overflow  = ovf_q;
  assign uart_port_DO = line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a default-rate instance checked cycle-exactly and a
// fast-divider instance (DIV=4) decoded by a line monitor for FIFO fill/wrap scenarios.
module tb_uart_tx_fifo;

  localparam int DDIV = 186;
  localparam int SDIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_clear = 1'b1, d_we = 1'b0;
  logic [7:0] d_di = 8'h00;
  logic       d_full, d_empty, d_busy, d_ovf, d_do;
  logic [4:0] d_count;

  logic       s_clear = 1'b1, s_we = 1'b0;
  logic [7:0] s_di = 8'h00;
  logic       s_full, s_empty, s_busy, s_ovf, s_do;
  logic [4:0] s_count;

  uart_tx_fifo u_dut (
    .clk(clk), .tx_clear(d_clear), .tx_DI(d_di), .tx_we(d_we),
    .tx_full(d_full), .tx_empty(d_empty), .tx_count(d_count),
    .tx_busy(d_busy), .tx_overflow(d_ovf), .uart_port_DO(d_do)
  );

  uart_tx_fifo #(.CLK_HZ(460800), .BAUD(115200), .DEPTH(16)) u_fast (
    .clk(clk), .tx_clear(s_clear), .tx_DI(s_di), .tx_we(s_we),
    .tx_full(s_full), .tx_empty(s_empty), .tx_count(s_count),
    .tx_busy(s_busy), .tx_overflow(s_ovf), .uart_port_DO(s_do)
  );

  int checks = 0;
  int failures = 0;

  // Line monitor for the fast instance: samples mid-bit and queues decoded bytes
  logic [7:0] rx_q[$];
  int         s_ferr = 0;
  logic [7:0] mon_b;
  logic       mon_ok;
  initial begin
    forever begin
      @(negedge clk);
      if (s_do === 1'b0) begin
        repeat (SDIV / 2) @(negedge clk);
        mon_ok = (s_do === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (SDIV) @(negedge clk);
          mon_b[k] = s_do;
        end
`ifdef UART_TX_PARITY_EN
        repeat (SDIV) @(negedge clk);
        if (s_do !== ^mon_b) mon_ok = 1'b0;
`endif
        repeat (SDIV) @(negedge clk);
        if (s_do !== 1'b1) mon_ok = 1'b0;
        rx_q.push_back(mon_b);
        if (!mon_ok) s_ferr++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic d_write(input logic [7:0] b);
    @(negedge clk);
    d_we = 1'b1;
    d_di = b;
    @(negedge clk);
    d_we = 1'b0;
    d_di = ~b;
  endtask

  // Cycle-exact frame check; call at the negedge of the first start-bit cycle
  task automatic d_frame(input logic [7:0] b, input string nm);
    logic exp, bad, act, actb;
    for (int k = 0; k < NB; k++) begin
      if (k == 0) exp = 1'b0;
      else if (k <= 8) exp = b[k-1];
      else if (k == NB - 1) exp = 1'b1;
      else exp = ^b;
      bad = 1'b0; act = exp; actb = 1'b1;
      for (int c = 0; c < DDIV; c++) begin
        if (!bad && (d_do !== exp || d_busy !== 1'b1)) begin
          bad = 1'b1; act = d_do; actb = d_busy;
        end
        if (!(k == NB - 1 && c == DDIV - 1)) @(negedge clk);
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d: line=%b busy=%b, expected line=%b busy=1", nm, k, act, actb, exp);
      end
    end
  endtask

  task automatic d_send_and_check(input logic [7:0] b, input string nm);
    d_write(b);
    checks++;
    if (d_empty !== 1'b0 || d_count !== 5'd1) begin
      failures++;
      $display("FAIL %s enqueue: empty=%b count=%0d, expected empty=0 count=1", nm, d_empty, d_count);
    end
    @(negedge clk);
    checks++;
    if (d_empty !== 1'b1 || d_count !== 5'd0 || d_do !== 1'b1 || d_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s pop: empty=%b count=%0d line=%b busy=%b, expected 1 0 1 0",
               nm, d_empty, d_count, d_do, d_busy);
    end
    @(negedge clk);
    d_frame(b, nm);
    @(negedge clk);
    checks++;
    if (d_do !== 1'b1 || d_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after frame: line=%b busy=%b, expected 1 0", nm, d_do, d_busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (d_do !== 1'b1 || d_busy !== 1'b0 || d_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset line: line=%b busy=%b ovf=%b, expected 1 0 0", d_do, d_busy, d_ovf);
    end
    checks++;
    if (d_empty !== 1'b1 || d_full !== 1'b0 || d_count !== 5'd0) begin
      failures++;
      $display("FAIL reset fifo: empty=%b full=%b count=%0d, expected 1 0 0", d_empty, d_full, d_count);
    end
    checks++;
    if (s_do !== 1'b1 || s_empty !== 1'b1 || s_count !== 5'd0) begin
      failures++;
      $display("FAIL reset fast: line=%b empty=%b count=%0d, expected 1 1 0", s_do, s_empty, s_count);
    end
    d_clear = 1'b0;
    s_clear = 1'b0;
  endtask

  task automatic test_single;
    d_send_and_check(8'h41, "single_41");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    d_we = 1'b1; d_di = 8'h41;
    @(negedge clk);
    checks++;
    if (d_count !== 5'd1) begin
      failures++;
      $display("FAIL b2b count0: count=%0d, expected 1", d_count);
    end
    d_di = 8'h42;
    @(negedge clk);
    d_we = 1'b0; d_di = 8'h00;
    checks++;
    if (d_count !== 5'd1 || d_empty !== 1'b0) begin
      failures++;
      $display("FAIL b2b count1: count=%0d empty=%b, expected 1 0", d_count, d_empty);
    end
    @(negedge clk);
    d_frame(8'h41, "b2b_first");
    @(negedge clk);
    checks++;
    if (d_do !== 1'b1 || d_busy !== 1'b0 || d_count !== 5'd0) begin
      failures++;
      $display("FAIL b2b gap: line=%b busy=%b count=%0d, expected 1 0 0", d_do, d_busy, d_count);
    end
    @(negedge clk);
    d_frame(8'h42, "b2b_second");
    @(negedge clk);
    checks++;
    if (d_do !== 1'b1 || d_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b end: line=%b busy=%b, expected 1 0", d_do, d_busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic bad;
    d_write(8'h55);
    d_write(8'h33);
    repeat (899) @(negedge clk);
    checks++;
    if (d_do !== 1'b0 || d_count !== 5'd1) begin
      failures++;
      $display("FAIL midreset pre: line=%b count=%0d, expected 0 1", d_do, d_count);
    end
    d_clear = 1'b1;
    @(negedge clk);
    d_clear = 1'b0;
    checks++;
    if (d_do !== 1'b1 || d_count !== 5'd0 || d_busy !== 1'b0 || d_ovf !== 1'b0 || d_empty !== 1'b1) begin
      failures++;
      $display("FAIL midreset post: line=%b count=%0d busy=%b ovf=%b empty=%b, expected 1 0 0 0 1",
               d_do, d_count, d_busy, d_ovf, d_empty);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (d_do !== 1'b1 || d_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midreset discard: line left idle after clear, expected line=1 busy=0");
    end
    d_send_and_check(8'h0F, "after_clear_0F");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    d_send_and_check(8'h07, "parity_07");
    d_send_and_check(8'h03, "parity_03");
  endtask
`endif

  task automatic test_overflow;
    int guard;
    rx_q.delete();
    @(negedge clk);
    s_we = 1'b1; s_di = 8'hAA;
    @(negedge clk);
    s_we = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_busy !== 1'b1 || s_empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf prior: busy=%b empty=%b, expected 1 1", s_busy, s_empty);
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        checks++;
        if (s_full !== 1'b1 || s_count !== 5'd16 || s_ovf !== 1'b0) begin
          failures++;
          $display("FAIL ovf full: full=%b count=%0d ovf=%b, expected 1 16 0", s_full, s_count, s_ovf);
        end
      end
      s_we = 1'b1;
      s_di = 8'(i);
    end
    @(negedge clk);
    s_we = 1'b0;
    checks++;
    if (s_ovf !== 1'b1 || s_count !== 5'd16 || s_full !== 1'b1) begin
      failures++;
      $display("FAIL ovf drop: ovf=%b count=%0d full=%b, expected 1 16 1", s_ovf, s_count, s_full);
    end
    guard = 0;
    while (rx_q.size() < 17 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (200) @(negedge clk);
    checks++;
    if (rx_q.size() != 17 || s_ferr != 0) begin
      failures++;
      $display("FAIL ovf frames: got %0d frames ferr=%0d, expected 17 frames ferr=0", rx_q.size(), s_ferr);
    end
    for (int k = 0; k < 17 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== ((k == 0) ? 8'hAA : 8'(k - 1))) begin
        failures++;
        $display("FAIL ovf order[%0d]: got %02h, expected %02h", k, rx_q[k], (k == 0) ? 8'hAA : 8'(k - 1));
      end
    end
    checks++;
    if (s_ovf !== 1'b1 || s_empty !== 1'b1 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf sticky: ovf=%b empty=%b busy=%b, expected 1 1 0", s_ovf, s_empty, s_busy);
    end
  endtask

  task automatic test_wrap_stream;
    int i, guard;
    @(negedge clk);
    s_clear = 1'b1;
    @(negedge clk);
    s_clear = 1'b0;
    checks++;
    if (s_ovf !== 1'b0 || s_count !== 5'd0) begin
      failures++;
      $display("FAIL wrap clear: ovf=%b count=%0d, expected 0 0", s_ovf, s_count);
    end
    rx_q.delete();
    s_ferr = 0;
    i = 0;
    guard = 0;
    while (i < 40 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (!s_full) begin
        s_we = 1'b1;
        s_di = 8'(i * 37 + 5);
        i++;
      end else begin
        s_we = 1'b0;
      end
    end
    @(negedge clk);
    s_we = 1'b0;
    guard = 0;
    while (rx_q.size() < 40 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (200) @(negedge clk);
    checks++;
    if (rx_q.size() != 40 || s_ferr != 0 || s_ovf !== 1'b0) begin
      failures++;
      $display("FAIL wrap frames: got %0d frames ferr=%0d ovf=%b, expected 40 0 0", rx_q.size(), s_ferr, s_ovf);
    end
    for (int k = 0; k < 40 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== 8'(k * 37 + 5)) begin
        failures++;
        $display("FAIL wrap order[%0d]: got %02h, expected %02h", k, rx_q[k], 8'(k * 37 + 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_overflow();
    test_wrap_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
